gray_seq_monitor: RTL and testbench

- Sits directly downstream of the 4-bit Gray-code counter and consumes its output code stream.
- Converts each sampled Gray code to binary and checks that consecutive samples form a legal +1 Gray sequence, including wrap.
- Reports lock status, per-sample step errors and a saturating error count for the verification environment and for status registers.

---
 rtl/gray_seq_monitor.sv | 102 ++++++++++
 tb/tb_gray_seq_monitor.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/gray_seq_monitor.sv
// gray_seq_monitor: converts a sampled Gray stream to binary and checks for legal +1 steps with lock tracking.
module gray_seq_monitor #(
   parameter int WIDTH       = 4,
   parameter int ERR_W       = 8,
   parameter int LOCK_N      = 2,
   parameter int ALLOW_STALL = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             in_valid,
   input  logic             clear_err,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             step_err,
   output logic             locked,
   output logic [ERR_W-1:0] err_count
);
   localparam int LW = $clog2(LOCK_N + 1);
   typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;
   state_t           state_q, state_d;
   logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
   logic [WIDTH-1:0] prev_bin_q, prev_bin_d, bin_out_q, bin_out_d, bin;
   logic             bin_valid_q, bin_valid_d, step_err_q, step_err_d, locked_q, locked_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic             legal, stall, bad;
   for (genvar i = 0; i < WIDTH; i++) begin : g_conv
      assign bin[i] = ^(gray_in >> i);
   end
   assign legal = bin == prev_bin_q + WIDTH'(1);
   assign stall = bin == prev_bin_q;
   assign bad   = !legal && !(stall && ALLOW_STALL != 0);
   always_comb begin
      state_d     = state_q;
      lock_cnt_d  = lock_cnt_q;
      prev_bin_d  = prev_bin_q;
      bin_out_d   = bin_out_q;
      bin_valid_d = 1'b0;
      step_err_d  = 1'b0;
      locked_d    = locked_q;
      if (in_valid) begin
         bin_out_d   = bin;
         bin_valid_d = 1'b1;
         prev_bin_d  = bin;
         case (state_q)
            IDLE: begin
               state_d    = ACQ;
               lock_cnt_d = '0;
            end
            ACQ: begin
               if (bad) begin
                  lock_cnt_d = '0;
               end else if (legal) begin
                  lock_cnt_d = lock_cnt_q + LW'(1);
                  if (lock_cnt_d == LW'(LOCK_N)) begin
                     state_d  = TRACK;
                     locked_d = 1'b1;
                  end
               end
            end
            TRACK: begin
               if (bad) begin
                  step_err_d = 1'b1;
                  state_d    = ACQ;
                  lock_cnt_d = '0;
                  locked_d   = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      // a clear coinciding with an error keeps that error counted
      err_count_d = clear_err ? ERR_W'(step_err_d)
                  : (step_err_d && !(&err_count_q)) ? err_count_q + ERR_W'(1) : err_count_q;
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         lock_cnt_q  <= '0;
         prev_bin_q  <= '0;
         bin_out_q   <= '0;
         bin_valid_q <= 1'b0;
         step_err_q  <= 1'b0;
         locked_q    <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         lock_cnt_q  <= lock_cnt_d;
         prev_bin_q  <= prev_bin_d;
         bin_out_q   <= bin_out_d;
         bin_valid_q <= bin_valid_d;
         step_err_q  <= step_err_d;
         locked_q    <= locked_d;
         err_count_q <= err_count_d;
      end
   end
   assign bin_out   = bin_out_q;
   assign bin_valid = bin_valid_q;
   assign step_err  = step_err_q;
   assign locked    = locked_q;
   assign err_count = err_count_q;
endmodule

// File: tb/tb_gray_seq_monitor.sv
// tb_gray_seq_monitor: two monitors (stall-tolerant 8-bit count, stall-strict 2-bit count) against a behavioural model.
module tb_gray_seq_monitor;
   localparam int LOCK_N = 2;
   logic       clk = 0, rstn = 0, in_valid = 0, clear_err = 0;
   logic [3:0] gray_in = '0;
   logic [3:0] bin_a, bin_b;
   logic       bv_a, bv_b, se_a, se_b, lk_a, lk_b;
   logic [7:0] ec_a;
   logic [1:0] ec_b;
   int vectors = 0, miscompares = 0, cur = 0;
   int g2b[16];
   int stall_ok[2] = '{1, 0};
   int errmax[2]   = '{255, 3};
   int m_prev[2], m_run[2], m_err[2], m_bin[2];
   bit m_started[2], m_locked[2], m_bv[2], m_se[2];

   always #5 clk = ~clk;

   gray_seq_monitor #(.WIDTH(4), .ERR_W(8), .LOCK_N(LOCK_N), .ALLOW_STALL(1)) dut_a (
      .clk(clk), .rstn(rstn), .gray_in(gray_in), .in_valid(in_valid), .clear_err(clear_err),
      .bin_out(bin_a), .bin_valid(bv_a), .step_err(se_a), .locked(lk_a), .err_count(ec_a));
   gray_seq_monitor #(.WIDTH(4), .ERR_W(2), .LOCK_N(LOCK_N), .ALLOW_STALL(0)) dut_b (
      .clk(clk), .rstn(rstn), .gray_in(gray_in), .in_valid(in_valid), .clear_err(clear_err),
      .bin_out(bin_b), .bin_valid(bv_b), .step_err(se_b), .locked(lk_b), .err_count(ec_b));

   task automatic chk(input string tag, input logic [31:0] act, input int exp);
      assert (act === 32'(exp)) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d (vector %0d)", tag, act, exp, vectors);
      end
   endtask

   task automatic model(input int k, input int g, input bit v, input bit c, input bit r);
      int b;
      bit ok, rep, bad;
      if (!r) begin
         m_started[k] = 0; m_prev[k] = 0; m_run[k] = 0; m_locked[k] = 0;
         m_err[k] = 0; m_bin[k] = 0; m_bv[k] = 0; m_se[k] = 0;
         return;
      end
      m_bv[k] = v;
      m_se[k] = 0;
      if (v) begin
         b   = g2b[g];
         ok  = b == (m_prev[k] + 1) % 16;
         rep = b == m_prev[k];
         bad = !ok && !(rep && stall_ok[k] != 0);
         if (!m_started[k]) begin
            m_started[k] = 1;
            m_run[k] = 0;
         end else if (m_locked[k]) begin
            if (bad) begin m_se[k] = 1; m_locked[k] = 0; m_run[k] = 0; end
         end else if (bad) begin
            m_run[k] = 0;
         end else if (ok) begin
            m_run[k]++;
            if (m_run[k] == LOCK_N) begin m_locked[k] = 1; m_run[k] = 0; end
         end
         m_prev[k] = b;
         m_bin[k]  = b;
      end
      if (c) m_err[k] = int'(m_se[k]);
      else if (m_se[k] && m_err[k] < errmax[k]) m_err[k]++;
   endtask

   task automatic step(input logic [3:0] g, input bit v, input bit c, input bit r);
      gray_in = g; in_valid = v; clear_err = c; rstn = r;
      @(posedge clk);
      for (int k = 0; k < 2; k++) model(k, int'(g), v, c, r);
      if (!r) cur = 0;
      else if (v) cur = g2b[g];
      #1;
      vectors++;
      chk("a_bin_out", 32'(bin_a), m_bin[0]);
      chk("a_bin_valid", 32'(bv_a), int'(m_bv[0]));
      chk("a_step_err", 32'(se_a), int'(m_se[0]));
      chk("a_locked", 32'(lk_a), int'(m_locked[0]));
      chk("a_err_count", 32'(ec_a), m_err[0]);
      chk("b_bin_out", 32'(bin_b), m_bin[1]);
      chk("b_bin_valid", 32'(bv_b), int'(m_bv[1]));
      chk("b_step_err", 32'(se_b), int'(m_se[1]));
      chk("b_locked", 32'(lk_b), int'(m_locked[1]));
      chk("b_err_count", 32'(ec_b), m_err[1]);
   endtask

   task automatic sendb(input int b, input bit c = 0);
      step(4'(b ^ (b >> 1)), 1, c, 1);
   endtask

   task automatic run(input int n);
      repeat (n) sendb((cur + 1) % 16);
   endtask

   task automatic idle(input bit c = 0);
      step(gray_in, 0, c, 1);
   endtask

   initial begin
      for (int b = 0; b < 16; b++) g2b[b ^ (b >> 1)] = b;
      step(4'b0000, 0, 0, 0);
      step(4'b1111, 1, 1, 0);
      // basic lock, then a long run across the 15 -> 0 wrap
      sendb(0);
      run(21);
      idle();
      // jump 5 -> 7 while locked, then two illegal steps in ACQ and a relock
      sendb(7);
      sendb(6);
      sendb(5);
      run(3);
      run(10);
      idle();
      sendb(2);
      sendb(2);
      sendb(2);
      run(3);
      // drive the narrow counter into saturation
      repeat (5) begin
         run(3);
         sendb((cur + 3) % 16);
      end
      run(3);
      sendb((cur + 3) % 16, 1);
      idle(1);
      // reset while tracking with two errors recorded
      repeat (2) begin
         run(3);
         sendb((cur + 3) % 16);
      end
      run(3);
      step(gray_in, 1, 0, 0);
      sendb(9);
      sendb(3);
      run(4);
      // randomized traffic
      repeat (600) begin
         int x, b;
         bit v, c, r;
         v = $urandom_range(0, 99) < 85;
         c = $urandom_range(0, 99) < 3;
         r = $urandom_range(0, 199) != 0;
         x = $urandom_range(0, 9);
         b = (x < 7) ? (cur + 1) % 16 : (x < 8) ? cur : int'($urandom_range(0, 15));
         step(4'(b ^ (b >> 1)), v, c, r);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
